// File: rtl/id_exe_skid_reg.sv
// Elastic ID->EXE pipeline register: one main entry driving EXE plus one skid entry.
// Optional perf counters under `ID_EXE_PERF_CNT_EN` (issued, flushed, stall).
module id_exe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_val_rn,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [11:0]       in_shift_operand,
  input  logic              in_imm,
  input  logic [3:0]        in_exe_cmd,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic              in_wb_en,
  input  logic              in_b,
  input  logic              in_s,
  input  logic [3:0]        in_dest,
  input  logic [3:0]        in_status,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [11:0]       out_shift_operand,
  output logic              out_imm,
  output logic [3:0]        out_exe_cmd,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic              out_wb_en,
  output logic              out_b,
  output logic              out_s,
  output logic [3:0]        out_dest,
  output logic [3:0]        out_status,
  output logic              out_load_store
`ifdef ID_EXE_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_issued
  , output logic [CNT_W-1:0] perf_flushed
  , output logic [CNT_W-1:0] perf_stall
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              b;
    logic              s;
    logic [3:0]        dest;
    logic [3:0]        status;
  } entry_t;

  entry_t main_q, skid_q, in_e;
  logic   main_valid, skid_valid;
  logic   accept, pop;

  // Killed entries keep their data but must not carry side-effecting controls.
  function automatic entry_t kill_ctrl(entry_t e);
    entry_t r;
    r          = e;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    r.wb_en    = 1'b0;
    r.b        = 1'b0;
    r.s        = 1'b0;
    return r;
  endfunction

  assign in_e = '{pc: in_pc, val_rn: in_val_rn, val_rm: in_val_rm,
                  shift_operand: in_shift_operand, imm: in_imm,
                  exe_cmd: in_exe_cmd, mem_r_en: in_mem_r_en,
                  mem_w_en: in_mem_w_en, wb_en: in_wb_en, b: in_b, s: in_s,
                  dest: in_dest, status: in_status};

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= kill_ctrl(main_q);
      skid_q     <= kill_ctrl(skid_q);
    end else if (!main_valid) begin
      if (accept) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (pop && accept) begin
        main_q <= in_e;
      end else if (pop) begin
        main_valid <= 1'b0;
      end else if (accept) begin
        skid_q     <= in_e;
        skid_valid <= 1'b1;
      end
    end else if (pop) begin
      // Skid drains into main; newer input cannot arrive here since in_ready=0.
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end
  end

  assign out_valid         = main_valid;
  assign out_pc            = main_q.pc;
  assign out_val_rn        = main_q.val_rn;
  assign out_val_rm        = main_q.val_rm;
  assign out_shift_operand = main_q.shift_operand;
  assign out_imm           = main_q.imm;
  assign out_exe_cmd       = main_q.exe_cmd;
  assign out_mem_r_en      = main_q.mem_r_en;
  assign out_mem_w_en      = main_q.mem_w_en;
  assign out_wb_en         = main_q.wb_en;
  assign out_b             = main_q.b;
  assign out_s             = main_q.s;
  assign out_dest          = main_q.dest;
  assign out_status        = main_q.status;
  assign out_load_store    = main_q.mem_r_en | main_q.mem_w_en;

`ifdef ID_EXE_PERF_CNT_EN
  logic [1:0]     kill_n;
  logic [CNT_W:0] flushed_sum;

  // An entry consumed by EXE in the flush cycle counts as issued, not killed.
  assign kill_n      = {1'b0, main_valid & ~pop} + {1'b0, skid_valid};
  assign flushed_sum = {1'b0, perf_flushed} + {{(CNT_W-1){1'b0}}, kill_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && perf_issued != '1)
        perf_issued <= perf_issued + 1'b1;
      if (flush)
        perf_flushed <= flushed_sum[CNT_W] ? '1 : flushed_sum[CNT_W-1:0];
      if (in_valid && !in_ready && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: doc/id_exe_skid_reg.md
Name: id_exe_skid_reg

Overview:
- Elastic ID->EXE pipeline register. It captures decoded instruction fields and register-file operands from the ID stage.
- It presents them to the EXE stage, which includes the val2 generator (val_Rm, shift_operand, imm, load_store) and the ALU.
- It uses a valid/ready handshake on both sides with a 2-entry skid buffer, so upstream stalls are decoupled from EXE backpressure.
- A synchronous flush (taken branch) kills all buffered instructions.

Parameters:
- DATA_W, 32, width of PC and of each operand (val_Rn, val_Rm).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all buffered instructions (branch taken).
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  register can accept (skid entry empty).
- in_pc  in  DATA_W  instruction PC+4.
- in_val_rn  in  DATA_W  Rn operand.
- in_val_rm  in  DATA_W  Rm operand.
- in_shift_operand  in  12  instruction bits [11:0].
- in_imm  in  1  I bit.
- in_exe_cmd  in  4  ALU command.
- in_mem_r_en  in  1  load.
- in_mem_w_en  in  1  store.
- in_wb_en  in  1  writeback enable.
- in_b  in  1  branch.
- in_s  in  1  update status.
- in_dest  in  4  destination register.
- in_status  in  4  NZCV at decode.
- out_valid  out  1  EXE holds a valid instruction.
- out_ready  in  1  EXE consumes the instruction this cycle.
- out_pc, out_val_rn, out_val_rm, out_shift_operand, out_imm, out_exe_cmd, out_mem_r_en, out_mem_w_en, out_wb_en, out_b, out_s, out_dest, out_status  out  same widths as in_*  registered fields.
- out_load_store  out  1  out_mem_r_en | out_mem_w_en, combinational from registered fields; drives val2 generator load_store.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Storage: main entry (drives out_*) plus one skid entry. Each entry has a valid bit.
- Reset: both valid bits 0, all stored fields 0. So out_valid=0, all out_*=0, out_load_store=0, in_ready=1 in the cycle after rst is sampled high.
- in_ready = ~skid_valid. It is registered-state only, with no combinational path from out_ready.
- Accept condition: in_valid & in_ready & ~flush.
- Pop condition: out_valid & out_ready.
- State transitions per cycle, evaluated on (main_valid, skid_valid):
  - EMPTY (0,0): accept -> main loads input -> MAIN.
  - MAIN (1,0):
    - pop & accept -> main loads input, stays MAIN.
    - pop only -> EMPTY.
    - accept without pop -> skid loads input -> FULL.
    - neither -> hold.
  - FULL (1,1): in_ready=0, no accept.
    - pop -> main loads skid, skid_valid=0 -> MAIN.
    - no pop -> hold.
- Latency: 1 cycle from accept to out_valid when EMPTY, or when MAIN with a pop in the same cycle.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Ordering is strictly FIFO. The skid entry is never bypassed by newer input.
- Output data stability: out_* must not change while out_valid=1 and out_ready=0.
- Flush:
  - Next cycle main_valid=0, skid_valid=0.
  - The input presented in the flush cycle is dropped.
  - flush overrides accept and pop when simultaneous. The EXE-side consume in the flush cycle still completes.
  - Control fields of killed entries (mem_r_en, mem_w_en, wb_en, b, s) are cleared to 0. Data fields may hold stale values.
- rst asserted mid-operation behaves identically to the reset state above, regardless of the current state.
- Data fields are updated only on load. Nothing toggles during hold, for power.

Optional Feature:
- Macro: ID_EXE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_issued [CNT_W] (counts pops) and perf_flushed [CNT_W] (counts valid entries killed by flush, 0/1/2 per flush; the dropped input is not counted).
  - Adds perf_stall [CNT_W] (counts cycles with in_valid & ~in_ready).
  - All counters reset to 0 on rst and saturate at all-ones (no wrap).
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> out_valid=0, in_ready=1, out_wb_en=0, out_shift_operand=12'h000.
- Streaming: 8 back-to-back instructions (in_pc=4,8,...,32), out_ready=1 -> same order at output, 1-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0 while sending pc=4,8 -> FULL, in_ready=0, out_pc=4 stable. Then out_ready=1 -> pc=4 then pc=8 emerge, in_ready=1 one cycle after first pop.
- Flush in FULL with in_valid=1 (pc=12) -> next cycle out_valid=0, in_ready=1, pc=12 never appears; optional perf_flushed=2.
- Load/store: in_mem_r_en=1, in_shift_operand=12'hFFC -> out_load_store=1, out_shift_operand=12'hFFC. Store-only case (in_mem_w_en=1) -> out_load_store=1. Neither -> 0.
- Optional counters: preload near max (force 16'hFFFE), issue 3 pops -> perf_issued=16'hFFFF, no wrap.
